// File: rtl/prt_pkg.sv
// prt_pkg: shared defaults, width helpers and state encodings for the packet table.
package prt_pkg;
   localparam int DEF_NUM_SLOTS   = 4;
   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_FRAME_DEPTH = 16;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int len_w(input int n);
      return $clog2(n + 1);
   endfunction
   typedef enum logic [1:0] {FREE, WRITING, VALID} slot_state_e;
   typedef enum logic {W_IDLE, W_ACTIVE} wr_state_e;
   typedef enum logic {R_IDLE, R_ACTIVE} rd_state_e;
endpackage

// File: rtl/prt_frame_mem.sv
// prt_frame_mem: beat storage, one write port and one asynchronous read port, addressed by {slot, beat}.
module prt_frame_mem #(
   parameter int AW = 6,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [2**AW];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/prt_multi_table.sv
// prt_multi_table: multi-slot packet table with independent write (allocate/fill/commit)
// and read (select/stream) engines sharing one frame store.
module prt_multi_table
   import prt_pkg::*;
#(
   parameter int NUM_SLOTS   = DEF_NUM_SLOTS,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int FRAME_DEPTH = DEF_FRAME_DEPTH,
   localparam int SLOT_W = idx_w(NUM_SLOTS),
   localparam int LEN_W  = len_w(FRAME_DEPTH),
   localparam int CNT_W  = len_w(NUM_SLOTS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  EN_start_writing_prt_entry,
   output logic [SLOT_W-1:0]     start_writing_prt_entry,
   output logic                  RDY_start_writing_prt_entry,
   input  logic [DATA_WIDTH-1:0] write_prt_entry_data,
   input  logic                  EN_write_prt_entry,
   output logic                  RDY_write_prt_entry,
   input  logic                  EN_finish_writing_prt_entry,
   output logic                  RDY_finish_writing_prt_entry,
   input  logic [SLOT_W-1:0]     invalidate_prt_entry_slot,
   input  logic                  EN_invalidate_prt_entry,
   output logic                  RDY_invalidate_prt_entry,
   input  logic [SLOT_W-1:0]     start_reading_prt_entry_slot,
   input  logic                  EN_start_reading_prt_entry,
   output logic                  RDY_start_reading_prt_entry,
   input  logic                  EN_read_prt_entry,
   output logic [DATA_WIDTH:0]   read_prt_entry,
   output logic                  RDY_read_prt_entry,
   output logic                  is_prt_slot_free,
   output logic                  RDY_is_prt_slot_free,
   output logic [CNT_W-1:0]      free_slot_count
);
   localparam int BEAT_W = idx_w(FRAME_DEPTH);
   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(FRAME_DEPTH);

   slot_state_e slot_st [NUM_SLOTS];
   slot_state_e slot_nxt [NUM_SLOTS];
   logic [LEN_W-1:0] slot_len [NUM_SLOTS];
   wr_state_e w_st, w_nxt;
   rd_state_e r_st, r_nxt;
   logic [SLOT_W-1:0] w_slot, r_slot, alloc_slot;
   logic [LEN_W-1:0] w_cnt, r_ptr;
   logic [CNT_W-1:0] cnt_nxt;
   logic [DATA_WIDTH-1:0] rdata;
   logic fire_sw, fire_w, fire_fin, fire_sr, fire_rd, inv_ok, last;

   assign RDY_start_writing_prt_entry  = (w_st == W_IDLE) && is_prt_slot_free;
   assign RDY_write_prt_entry          = (w_st == W_ACTIVE) && (w_cnt < DEPTH_L);
   assign RDY_finish_writing_prt_entry = (w_st == W_ACTIVE) && (w_cnt != '0);
   assign RDY_start_reading_prt_entry  = (r_st == R_IDLE);
   assign RDY_read_prt_entry           = (r_st == R_ACTIVE);
   assign RDY_invalidate_prt_entry     = 1'b1;
   assign RDY_is_prt_slot_free         = 1'b1;

   assign fire_sw  = EN_start_writing_prt_entry && RDY_start_writing_prt_entry;
   assign fire_w   = EN_write_prt_entry && RDY_write_prt_entry;
   assign fire_fin = EN_finish_writing_prt_entry && RDY_finish_writing_prt_entry;
   assign fire_sr  = EN_start_reading_prt_entry && RDY_start_reading_prt_entry;
   assign fire_rd  = EN_read_prt_entry && RDY_read_prt_entry;
   // A slot being read, or about to be, is pinned against invalidation.
   assign inv_ok = EN_invalidate_prt_entry && (slot_st[invalidate_prt_entry_slot] == VALID)
                   && !((r_st == R_ACTIVE) && (r_slot == invalidate_prt_entry_slot))
                   && !(fire_sr && (start_reading_prt_entry_slot == invalidate_prt_entry_slot));
   assign last = (r_ptr == slot_len[r_slot] - LEN_W'(1));
   assign read_prt_entry = RDY_read_prt_entry ? {last, rdata} : '0;
   assign start_writing_prt_entry = alloc_slot;

   always_comb begin
      alloc_slot = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--)
         if (slot_st[i] == FREE) alloc_slot = SLOT_W'(i);
   end

   always_comb begin
      slot_nxt = slot_st;
      if (fire_sw) slot_nxt[alloc_slot] = WRITING;
      if (fire_fin) slot_nxt[w_slot] = VALID;
      if (inv_ok) slot_nxt[invalidate_prt_entry_slot] = FREE;
      cnt_nxt = '0;
      for (int i = 0; i < NUM_SLOTS; i++)
         cnt_nxt = cnt_nxt + CNT_W'(slot_nxt[i] == FREE);
   end

   always_comb begin
      w_nxt = fire_sw ? W_ACTIVE : fire_fin ? W_IDLE : w_st;
      r_nxt = (fire_sr && slot_st[start_reading_prt_entry_slot] == VALID) ? R_ACTIVE :
              (fire_rd && last) ? R_IDLE : r_st;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         w_st <= W_IDLE;
         r_st <= R_IDLE;
         w_slot <= '0;
         w_cnt <= '0;
         r_slot <= '0;
         r_ptr <= '0;
         free_slot_count <= CNT_W'(NUM_SLOTS);
         is_prt_slot_free <= 1'b1;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_st[i] <= FREE;
            slot_len[i] <= '0;
         end
      end else begin
         w_st <= w_nxt;
         r_st <= r_nxt;
         slot_st <= slot_nxt;
         free_slot_count <= cnt_nxt;
         is_prt_slot_free <= (cnt_nxt != '0);
         if (fire_sw) begin
            w_slot <= alloc_slot;
            w_cnt <= '0;
         end else if (fire_w) w_cnt <= w_cnt + LEN_W'(1);
         if (fire_fin) slot_len[w_slot] <= w_cnt;
         if (fire_sr) begin
            r_slot <= start_reading_prt_entry_slot;
            r_ptr <= '0;
         end else if (fire_rd) r_ptr <= r_ptr + LEN_W'(1);
      end

   prt_frame_mem #(.AW(SLOT_W + BEAT_W), .DW(DATA_WIDTH)) u_mem (
      .clk   (clk),
      .we    (fire_w),
      .waddr ({w_slot, w_cnt[BEAT_W-1:0]}),
      .wdata (write_prt_entry_data),
      .raddr ({r_slot, r_ptr[BEAT_W-1:0]}),
      .rdata (rdata)
   );

   a_sw:  assert property (@(posedge clk) disable iff (!rst_n) EN_start_writing_prt_entry |-> RDY_start_writing_prt_entry);
   a_w:   assert property (@(posedge clk) disable iff (!rst_n) EN_write_prt_entry |-> RDY_write_prt_entry);
   a_fin: assert property (@(posedge clk) disable iff (!rst_n) EN_finish_writing_prt_entry |-> RDY_finish_writing_prt_entry);
   a_sr:  assert property (@(posedge clk) disable iff (!rst_n) EN_start_reading_prt_entry |-> RDY_start_reading_prt_entry);
   a_rd:  assert property (@(posedge clk) disable iff (!rst_n) EN_read_prt_entry |-> RDY_read_prt_entry);
endmodule

// File: tb/tb_prt_multi_table.sv
// tb_prt_multi_table: directed scenarios plus randomized traffic against a queue-based table model.
module tb_prt_multi_table;
   localparam int NS = 4;
   localparam int DW = 8;
   localparam int FD = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic en_sw, en_w, en_fin, en_inv, en_sr, en_rd;
   logic [DW-1:0] wdata;
   logic [1:0] inv_slot, sr_slot;
   logic [1:0] sw_slot;
   logic rdy_sw, rdy_w, rdy_fin, rdy_inv, rdy_sr, rdy_rd, slot_free, rdy_free;
   logic [DW:0] rd_data;
   logic [2:0] free_cnt;

   int st [NS];
   logic [DW-1:0] frame [NS][$];
   logic [DW-1:0] wbuf [$];
   bit w_on, r_on;
   int w_slot, r_slot, r_ptr;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   prt_multi_table dut (
      .clk                          (clk),
      .rst_n                        (rst_n),
      .EN_start_writing_prt_entry   (en_sw),
      .start_writing_prt_entry      (sw_slot),
      .RDY_start_writing_prt_entry  (rdy_sw),
      .write_prt_entry_data         (wdata),
      .EN_write_prt_entry           (en_w),
      .RDY_write_prt_entry          (rdy_w),
      .EN_finish_writing_prt_entry  (en_fin),
      .RDY_finish_writing_prt_entry (rdy_fin),
      .invalidate_prt_entry_slot    (inv_slot),
      .EN_invalidate_prt_entry      (en_inv),
      .RDY_invalidate_prt_entry     (rdy_inv),
      .start_reading_prt_entry_slot (sr_slot),
      .EN_start_reading_prt_entry   (en_sr),
      .RDY_start_reading_prt_entry  (rdy_sr),
      .EN_read_prt_entry            (en_rd),
      .read_prt_entry               (rd_data),
      .RDY_read_prt_entry           (rdy_rd),
      .is_prt_slot_free             (slot_free),
      .RDY_is_prt_slot_free         (rdy_free),
      .free_slot_count              (free_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // st encoding in the model: 0 free, 1 being written, 2 holds a committed frame
   function automatic int m_free_cnt();
      int n = 0;
      foreach (st[i]) if (st[i] == 0) n++;
      return n;
   endfunction
   function automatic int m_alloc();
      for (int i = 0; i < NS; i++) if (st[i] == 0) return i;
      return 0;
   endfunction
   function automatic bit m_rdy_sw();  return !w_on && m_free_cnt() > 0;     endfunction
   function automatic bit m_rdy_w();   return w_on && wbuf.size() < FD;       endfunction
   function automatic bit m_rdy_fin(); return w_on && wbuf.size() > 0;        endfunction
   function automatic logic [DW:0] m_read();
      if (!r_on) return '0;
      return {r_ptr == frame[r_slot].size() - 1, frame[r_slot][r_ptr]};
   endfunction

   task automatic check_all();
      check("alloc", sw_slot, m_alloc());
      check("rdy_sw", rdy_sw, m_rdy_sw());
      check("rdy_w", rdy_w, m_rdy_w());
      check("rdy_fin", rdy_fin, m_rdy_fin());
      check("rdy_sr", rdy_sr, !r_on);
      check("rdy_rd", rdy_rd, r_on);
      check("rdy_inv", rdy_inv, 1);
      check("rdy_free", rdy_free, 1);
      check("read", rd_data, m_read());
      check("free_cnt", free_cnt, m_free_cnt());
      check("slot_free", slot_free, m_free_cnt() > 0);
   endtask

   task automatic step();
      bit sw, w, fin, rd, sr_ok, inv_ok;
      int a;
      sw = en_sw && m_rdy_sw();
      w = en_w && m_rdy_w();
      fin = en_fin && m_rdy_fin();
      rd = en_rd && r_on;
      sr_ok = en_sr && !r_on && st[sr_slot] == 2;
      inv_ok = en_inv && st[inv_slot] == 2 && !(r_on && r_slot == int'(inv_slot))
               && !(en_sr && !r_on && sr_slot == inv_slot);
      a = m_alloc();
      @(posedge clk);
      #1;
      if (sw) begin w_on = 1; w_slot = a; st[a] = 1; wbuf.delete(); end
      if (w) wbuf.push_back(wdata);
      if (fin) begin frame[w_slot] = wbuf; st[w_slot] = 2; w_on = 0; end
      if (rd) begin r_ptr++; if (r_ptr == frame[r_slot].size()) r_on = 0; end
      if (sr_ok) begin r_on = 1; r_slot = sr_slot; r_ptr = 0; end
      if (inv_ok) st[inv_slot] = 0;
      check_all();
   endtask

   task automatic idle_inputs();
      {en_sw, en_w, en_fin, en_inv, en_sr, en_rd} = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      #1;
      foreach (st[i]) st[i] = 0;
      w_on = 0;
      r_on = 0;
      wbuf.delete();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic write_frame(input int n, input logic [DW-1:0] base);
      en_sw = 1; step(); en_sw = 0;
      en_w = 1;
      for (int i = 0; i < n; i++) begin wdata = base + DW'(i); step(); end
      en_w = 0;
      en_fin = 1; step(); en_fin = 0;
   endtask

   task automatic invalidate(input logic [1:0] s);
      en_inv = 1; inv_slot = s; step(); en_inv = 0;
   endtask

   initial begin
      idle_inputs();
      wdata = '0;
      inv_slot = '0;
      sr_slot = '0;
      #2;
      do_reset();
      check("reset_cnt", free_cnt, 4);
      check("reset_rdy_sw", rdy_sw, 1);

      write_frame(3, 8'hA1);
      en_sr = 1; sr_slot = 0; step(); en_sr = 0;
      check("b0", rd_data, 9'h0A1);
      en_rd = 1; step();
      check("b1", rd_data, 9'h0A2);
      step();
      check("b2", rd_data, 9'h1A3);
      step(); en_rd = 0;
      check("read_done", rdy_rd, 0);
      en_sr = 1; sr_slot = 0; step(); en_sr = 0;
      check("still_valid", rdy_rd, 1);
      en_rd = 1; repeat (3) step(); en_rd = 0;

      for (int s = 1; s < NS; s++) write_frame(1, 8'hB0 + 8'(s));
      check("full_free", slot_free, 0);
      check("full_cnt", free_cnt, 0);
      check("full_rdy_sw", rdy_sw, 0);
      invalidate(2);
      check("realloc", sw_slot, 2);
      write_frame(2, 8'hC0);

      en_inv = 1; inv_slot = 1; en_sr = 1; sr_slot = 1; step();
      en_inv = 0; en_sr = 0;
      check("pin_rd", rdy_rd, 1);
      check("pin_cnt", free_cnt, 0);
      check("pin_data", rd_data, 9'h1B1);
      en_rd = 1; step(); en_rd = 0;
      invalidate(1);
      check("inv_after", free_cnt, 1);

      invalidate(0); invalidate(2); invalidate(3);
      en_sw = 1; step(); en_sw = 0;
      en_w = 1;
      for (int i = 0; i < FD; i++) begin wdata = 8'h40 + 8'(i); step(); end
      en_w = 0;
      check("depth_full", rdy_w, 0);
      en_fin = 1; step(); en_fin = 0;
      en_sr = 1; sr_slot = 0; step(); en_sr = 0;
      for (int i = 0; i < FD; i++) begin
         check("deep_last", rd_data[DW], i == FD - 1);
         en_sr = 0; en_rd = 1;
         if (i == 0) en_sw = 1;
         else if (i < 6) begin en_sw = 0; en_w = 1; wdata = 8'h90 + 8'(i); end
         else begin en_w = 0; en_fin = m_rdy_fin(); end
         step();
         en_fin = 0;
      end
      idle_inputs();
      en_sr = 1; sr_slot = 1; step(); en_sr = 0;
      en_rd = 1;
      for (int i = 0; i < FD && r_on; i++) step();
      en_rd = 0;
      check("concurrent_done", rdy_rd, 0);

      invalidate(1);
      en_sw = 1; step(); en_sw = 0;
      en_w = 1; wdata = 8'h11; step(); wdata = 8'h22; step(); en_w = 0;
      do_reset();
      check("rst_cnt", free_cnt, 4);
      check("rst_rdy_sw", rdy_sw, 1);
      check("rst_rdy_w", rdy_w, 0);
      check("rst_rdy_fin", rdy_fin, 0);
      check("rst_rdy_rd", rdy_rd, 0);
      check("rst_read", rd_data, 0);

      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) do_reset();
         en_sw = m_rdy_sw() && $urandom_range(0, 3) == 0;
         en_fin = m_rdy_fin() && $urandom_range(0, 5) == 0;
         en_w = m_rdy_w() && !en_fin && $urandom_range(0, 1) == 0;
         en_sr = !r_on && $urandom_range(0, 2) == 0;
         sr_slot = 2'($urandom);
         en_rd = r_on && $urandom_range(0, 1) == 0;
         en_inv = $urandom_range(0, 4) == 0;
         inv_slot = 2'($urandom);
         wdata = 8'($urandom);
         step();
      end
      idle_inputs();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/prt_multi_table.md
PRT_MULTI_TABLE -- requirements
Module: prt_multi_table

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4: number of packet slots, at least 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: beat width in bits.
REQ-003 SHALL have parameter FRAME_DEPTH, default 16: maximum beats per slot.
REQ-004 SHALL have these derived widths:
- SLOT_W = max(1, clog2(NUM_SLOTS))
- LEN_W = clog2(FRAME_DEPTH+1)
- CNT_W = clog2(NUM_SLOTS+1)
REQ-005 SHALL have these ports, name / direction / width / meaning:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- EN_start_writing_prt_entry  in  1  allocate a slot
- start_writing_prt_entry  out  SLOT_W  slot to be allocated
- RDY_start_writing_prt_entry  out  1
- write_prt_entry_data  in  DATA_WIDTH  beat data
- EN_write_prt_entry  in  1  write a beat
- RDY_write_prt_entry  out  1
- EN_finish_writing_prt_entry  in  1  commit the frame
- RDY_finish_writing_prt_entry  out  1
- invalidate_prt_entry_slot  in  SLOT_W  slot to free
- EN_invalidate_prt_entry  in  1
- RDY_invalidate_prt_entry  out  1
- start_reading_prt_entry_slot  in  SLOT_W  slot to read
- EN_start_reading_prt_entry  in  1
- RDY_start_reading_prt_entry  out  1
- EN_read_prt_entry  in  1  consume a beat
- read_prt_entry  out  DATA_WIDTH+1  {last, data}
- RDY_read_prt_entry  out  1
- is_prt_slot_free  out  1  at least one slot is FREE
- RDY_is_prt_slot_free  out  1  constant 1
- free_slot_count  out  CNT_W  number of FREE slots

Function
REQ-006 Each slot SHALL hold a state FREE/WRITING/VALID, a registered length of LEN_W bits, and FRAME_DEPTH storage beats.
REQ-007 Write FSM SHALL have states W_IDLE and W_ACTIVE; read FSM SHALL have states R_IDLE and R_ACTIVE; both operate independently and concurrently.
REQ-008 Every method SHALL fire only when EN and RDY are both 1; EN with RDY=0 SHALL be ignored and flagged by an assertion.
REQ-009 start_writing_prt_entry SHALL always show the lowest-index FREE slot (0 if none is free).
REQ-010 RDY_start_writing SHALL be 1 only in W_IDLE with is_prt_slot_free=1.
REQ-011 When start_writing fires: that slot becomes WRITING, its beat count clears to 0, and the FSM enters W_ACTIVE.
REQ-012 RDY_write SHALL be 1 in W_ACTIVE while count < FRAME_DEPTH.
REQ-013 Each write beat SHALL store data at the current count, then increment the count; at count == FRAME_DEPTH, RDY_write drops to 0 and data is never overwritten or wrapped.
REQ-014 RDY_finish SHALL be 1 in W_ACTIVE with count >= 1, so a zero-length frame cannot be committed.
REQ-015 When finish fires: length is set to count, the slot becomes VALID, and the FSM returns to W_IDLE.
REQ-016 RDY_start_reading SHALL be 1 in R_IDLE.
REQ-017 start_reading of a slot that is not VALID SHALL be a no-op, with the FSM staying in R_IDLE.
REQ-018 start_reading of a VALID slot SHALL set the read pointer to 0 and enter R_ACTIVE.
REQ-019 In R_ACTIVE, RDY_read SHALL be 1 and read_prt_entry SHALL present the current beat combinationally from registered state (zero-cycle latency), with last=1 when pointer == length-1.
REQ-020 EN_read SHALL advance the pointer; consuming the last beat SHALL return the FSM to R_IDLE.
REQ-021 Reading SHALL be non-destructive: the slot stays VALID after the last beat.
REQ-022 RDY_invalidate SHALL be constant 1.
REQ-023 Invalidate SHALL free the slot only if it is VALID and not the slot under active read; otherwise it is a no-op.
REQ-024 A slot freed in cycle N SHALL become allocatable in cycle N+1; start_writing in cycle N uses the pre-update free set.
REQ-025 free_slot_count and is_prt_slot_free SHALL be registered and reflect all state updates of the previous edge.
REQ-026 When RDY_read=0, read_prt_entry SHALL be 0.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately (asynchronously) set:
- all slots FREE, lengths 0, both FSMs idle
- free_slot_count=NUM_SLOTS, is_prt_slot_free=1
- RDY_start_writing=1, RDY_start_reading=1
- RDY_write=0, RDY_finish=0, RDY_read=0
- read_prt_entry=0
Storage contents are not reset.
REQ-028 Reset asserted mid-write or mid-read SHALL abandon the transaction; no partial frame becomes VALID.

Structure
REQ-029 Package prt_pkg SHALL hold the NUM_SLOTS, DATA_WIDTH and FRAME_DEPTH defaults, the width functions, the slot_state_e enum (FREE/WRITING/VALID) and the FSM state enums.
REQ-030 Storage SHALL be a sub-module prt_frame_mem: one write port, one asynchronous read port, addressed by {slot, beat}.

Verification
REQ-031 Allocate, write 3 beats (0xA1, 0xA2, 0xA3), finish slot 0, then read -> 0x0A1, 0x0A2, 0x1A3, then RDY_read=0, and slot 0 stays VALID.
REQ-032 Fill all 4 slots -> is_prt_slot_free=0, free_slot_count=0, RDY_start_writing=0; invalidate slot 2 -> next allocation returns slot 2.
REQ-033 Write 16 beats -> RDY_write=0 on the 17th attempt; read returns 16 beats with last only on beat 15.
REQ-034 Invalidate slot 1 in the same cycle as start_reading slot 1 -> read proceeds on the pre-update VALID state and invalidate of the reading slot is ignored; invalidate after the read completes -> FREE.
REQ-035 Assert rst_n low mid-write after 2 beats -> all RDY signals return to reset values and free_slot_count=4.
REQ-036 Read slot 0 while concurrently writing slot 1 -> both frames intact, with no beat corruption.
